// File: rtl/act_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module   : act_stream_unit
//  Brief    : Streaming LANES-wide activation stage (pass/ReLU/leaky/clip) with
//             frame position tracking, last-beat tag and done pulse.
//             Optional macro ACT_STATS_EN adds the zero_count output.
//  Revision : 1.0 - initial release
// ============================================================================
module act_stream_unit #(
    parameter int BITWIDTH   = 16,
    parameter int LANES      = 4,
    parameter int NUM_CH     = 2,
    parameter int MAP_H      = 28,
    parameter int MAP_W      = 28,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [BITWIDTH-2:0]       cap,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*BITWIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*BITWIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
`ifdef ACT_STATS_EN
    ,
    output logic [31:0]               zero_count
`endif
);

    localparam int c_DW    = LANES * BITWIDTH;
    localparam int c_COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int c_ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(MAP_W - LANES);
    localparam logic [c_COL_W-1:0] c_COL_STEP = c_COL_W'(LANES);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(MAP_H - 1);
    localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(NUM_CH - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACTIVE = 2'd1;
    localparam logic [1:0] c_S_DRAIN  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [1:0]          r_mode;
    logic [BITWIDTH-2:0] r_cap;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_CH_W-1:0]   r_ch;
    logic                r_s1_valid;
    logic                r_s1_last;
    logic [c_DW-1:0]     r_s1_data;
    logic                r_s2_valid;
    logic                r_s2_last;
    logic [c_DW-1:0]     r_s2_data;
    logic                r_done;
    logic [c_DW-1:0]     w_res;
    logic                w_start_ok;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_s2_load;
    logic                w_in_last;

    function automatic logic [BITWIDTH-1:0] f_act(
        input logic [BITWIDTH-1:0] x,
        input logic [1:0]          m,
        input logic [BITWIDTH-2:0] c
    );
        logic sgn;
        sgn = x[BITWIDTH-1];
        case (m)
            2'd0:    f_act = x;
            2'd1:    f_act = sgn ? '0 : x;
            2'd2:    f_act = sgn ? BITWIDTH'($signed(x) >>> LEAK_SHIFT) : x;
            default: f_act = sgn ? '0 : ((x[BITWIDTH-2:0] > c) ? {1'b0, c} : x);
        endcase
    endfunction

    assign w_start_ok = start && (r_state == c_S_IDLE);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;
    // S1 advances whenever S2 is empty or draining this cycle
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_in_last  = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST) && (r_ch == c_CH_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_state_nxt = c_S_ACTIVE;
            c_S_ACTIVE: if (w_in_fire && w_in_last) w_state_nxt = c_S_DRAIN;
            c_S_DRAIN:  if (w_out_fire && r_s2_last) w_state_nxt = c_S_IDLE;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != c_S_IDLE);
        in_ready = (r_state == c_S_ACTIVE) && (!r_s1_valid || w_s2_load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= '0;
            r_cap  <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_ch   <= '0;
        end else if (w_start_ok) begin
            r_mode <= mode;
            r_cap  <= cap;
            r_col  <= '0;
            r_row  <= '0;
            r_ch   <= '0;
        end else if (w_in_fire) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                if (r_row == c_ROW_LAST) begin
                    r_row <= '0;
                    r_ch  <= (r_ch == c_CH_LAST) ? '0 : r_ch + c_CH_W'(1);
                end else begin
                    r_row <= r_row + c_ROW_W'(1);
                end
            end else begin
                r_col <= r_col + c_COL_STEP;
            end
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_res[k*BITWIDTH +: BITWIDTH] = f_act(r_s1_data[k*BITWIDTH +: BITWIDTH], r_mode, r_cap);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= w_in_last;
                r_s1_data  <= in_data;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_last  <= r_s1_last;
                r_s2_data  <= w_res;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
            r_done <= w_out_fire && r_s2_last;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_last  = r_s2_last;
    assign done      = r_done;

`ifdef ACT_STATS_EN
    logic [31:0] r_zero_cnt;
    logic [31:0] w_neg_cnt;

    // Only negatives forced to zero are counted; clipping to cap is not
    always_comb begin
        w_neg_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            w_neg_cnt = w_neg_cnt + 32'(r_s1_data[k*BITWIDTH + BITWIDTH - 1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_zero_cnt <= '0;
        else if (w_start_ok)
            r_zero_cnt <= '0;
        else if (w_s2_load && (r_mode == 2'd1 || r_mode == 2'd3))
            r_zero_cnt <= r_zero_cnt + w_neg_cnt;
    end

    assign zero_count = r_zero_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_act_stream_unit
//  Brief    : Self-checking bench for act_stream_unit: directed frames with
//             literal expectations plus a queue-based activation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_act_stream_unit;

    localparam int c_BW    = 16;
    localparam int c_LN    = 4;
    localparam int c_DW    = c_BW * c_LN;
    localparam int c_SHIFT = 3;
    localparam int c_BEATS = 2 * 28 * 28 / 4;

    logic            clk = 1'b0;
    logic            rst, start, in_valid, out_ready;
    logic [1:0]      mode;
    logic [c_BW-2:0] cap;
    logic [c_DW-1:0] in_data;
    logic            in_ready, out_valid, out_last, busy, done;
    logic [c_DW-1:0] out_data;
`ifdef ACT_STATS_EN
    logic [31:0]     zero_count;
`endif

    always #5 clk = ~clk;

    act_stream_unit #(
        .BITWIDTH(c_BW), .LANES(c_LN), .NUM_CH(2), .MAP_H(28), .MAP_W(28), .LEAK_SHIFT(c_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cap(cap),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
`ifdef ACT_STATS_EN
        , .zero_count(zero_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Activation from its arithmetic definition; leaky uses floor division
    function automatic logic [15:0] model_lane(input logic [15:0] xs, input logic [1:0] m, input int c);
        int x, y, d;
        x = int'($signed(xs));
        d = 1 << c_SHIFT;
        case (m)
            2'd0:    y = x;
            2'd1:    y = (x < 0) ? 0 : x;
            2'd2:    y = (x < 0) ? -((-x + d - 1) / d) : x;
            default: y = (x < 0) ? 0 : ((x > c) ? c : x);
        endcase
        return y[15:0];
    endfunction

    typedef struct {
        logic [c_DW-1:0] d;
        logic            l;
    } beat_t;
    beat_t exp_q[$];

    logic [1:0]      m_mode;
    int              m_cap, m_zero, mon_acc, out_cnt, cyc;
    int              first_acc_cyc, first_out_cyc;
    bit              mon_active, exp_done, prev_stall, first_out_seen;
    logic [c_DW-1:0] prev_data, first_out_data, last_out_data;
    logic            prev_last;

    initial begin
        cyc = 0; mon_active = 0; exp_done = 0; prev_stall = 0; mon_acc = 0;
        out_cnt = 0; m_zero = 0; first_out_seen = 0; first_acc_cyc = 0; first_out_cyc = 0;
    end

    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (rst) begin
            exp_q.delete();
            mon_acc = 0; mon_active = 0; exp_done = 0; prev_stall = 0;
        end else begin
            chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
`ifdef ACT_STATS_EN
            if (exp_done) chk("zero_count_model", zero_count, 64'(m_zero));
`endif
            if (done) mon_active = 0;
            exp_done = 0;
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
            end
            if (mon_active && mon_acc == c_BEATS)
                chk("ready_in_drain", {63'd0, in_ready}, 64'd0);
            if (start && !busy) begin
                mon_active = 1; mon_acc = 0; out_cnt = 0; m_zero = 0;
                m_mode = mode; m_cap = int'(cap); first_out_seen = 0;
            end
            if (out_valid && !first_out_seen) begin
                first_out_seen = 1; first_out_cyc = cyc; first_out_data = out_data;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_data", out_data, b.d);
                    chk("out_last", {63'd0, out_last}, {63'd0, b.l});
                    exp_done = b.l;
                    last_out_data = out_data;
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                if (!mon_active || mon_acc >= c_BEATS) begin
                    chk("accept_beyond_frame", 64'd1, 64'd0);
                end else begin
                    for (int k = 0; k < c_LN; k++) begin
                        b.d[k*c_BW +: c_BW] = model_lane(in_data[k*c_BW +: c_BW], m_mode, m_cap);
                        if ((m_mode == 2'd1 || m_mode == 2'd3) && in_data[k*c_BW + c_BW - 1]) m_zero++;
                    end
                    b.l = (mon_acc == c_BEATS - 1);
                    exp_q.push_back(b);
                    if (mon_acc == 0) first_acc_cyc = cyc;
                    mon_acc++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // One frame: first beat b0, rest b1 (or random); mode/cap scrambled after start
    task automatic run_frame(input logic [1:0] m, input logic [c_BW-2:0] c,
                             input logic [c_DW-1:0] b0, input logic [c_DW-1:0] b1,
                             input int rdy_pct, input bit rnd, input int abort_at);
        int acc;
        bit got_done;
        acc = 0; got_done = 0;
        @(posedge clk); #1;
        start = 1; mode = m; cap = c; in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        for (int cy = 0; cy < 6000 && !got_done; cy++) begin
            start     = (cy == 50);
            mode      = 2'($urandom);
            cap       = 15'($urandom);
            out_ready = (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
            in_valid  = rnd ? ($urandom_range(3) != 0) : 1'b1;
            in_data   = (acc == 0) ? b0 : (rnd ? {$urandom, $urandom} : b1);
            @(negedge clk);
            if (done) got_done = 1;
            if (in_valid && in_ready) acc++;
            if (abort_at != 0 && acc == abort_at) begin
                @(posedge clk); #1;
                rst = 1; in_valid = 0; start = 0;
                #1;
                chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
                chk("abort_busy", {63'd0, busy}, 64'd0);
                chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
                chk("abort_out_data", out_data, 64'd0);
                repeat (2) @(posedge clk);
                #1 rst = 0;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_no_done", {63'd0, done}, 64'd0);
                end
                return;
            end
            @(posedge clk); #1;
        end
        start = 0; in_valid = 0; out_ready = 1;
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        chk("beat_count", 64'(out_cnt), 64'(c_BEATS));
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst = 1; start = 0; in_valid = 0; out_ready = 1; mode = 0; cap = 0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
`ifdef ACT_STATS_EN
        chk("rst_zero_count", zero_count, 64'd0);
`endif
        rst = 0;

        // ReLU {-5,0,7,-32768} -> {0,0,7,0}
        run_frame(2'd1, 15'd0, 64'h8000_0007_0000_FFFB, 64'h8000_0007_0000_FFFB, 100, 0, 0);
        chk("relu_latency", 64'(first_out_cyc - first_acc_cyc), 64'd2);
        chk("relu_first", first_out_data, 64'h0000_0007_0000_0000);
        chk("relu_last", last_out_data, 64'h0000_0007_0000_0000);

        // Leaky {-8,-1,-17,100} -> {-1,-1,-3,100}
        run_frame(2'd2, 15'd0, 64'h0064_FFEF_FFFF_FFF8, 64'h0064_FFEF_FFFF_FFF8, 100, 0, 0);
        chk("leaky_first", first_out_data, 64'h0064_FFFD_FFFF_FFFF);

        // Clip cap=6: {3,6,7,32767} -> {3,6,6,6}; {-1,-32768,5,0} -> {0,0,5,0}
        run_frame(2'd3, 15'd6, 64'h7FFF_0007_0006_0003, 64'h0000_0005_8000_FFFF, 100, 0, 0);
        chk("clip_first", first_out_data, 64'h0006_0006_0006_0003);
        chk("clip_last", last_out_data, 64'h0000_0005_0000_0000);

        run_frame(2'd2, 15'd0, 64'h1234_8001_FFFF_0000, 64'd0, 50, 1, 0);
        run_frame(2'd3, 15'd1000, 64'hFFF0_7FFF_03E8_03E9, 64'd0, 50, 1, 0);

        run_frame(2'd1, 15'd0, 64'h0001_FFFF_0002_FFFE, 64'd0, 100, 1, 100);
        run_frame(2'd0, 15'd0, 64'h8000_7FFF_FFFF_0001, 64'd0, 70, 1, 0);
        chk("clean_latency_ok", {63'd0, first_out_seen}, 64'd1);

`ifdef ACT_STATS_EN
        run_frame(2'd1, 15'd0, '1, '1, 100, 0, 0);
        chk("stats_relu", zero_count, 64'd1568);
        run_frame(2'd0, 15'd0, '1, '1, 100, 0, 0);
        chk("stats_pass", zero_count, 64'd0);
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/act_stream_unit.md
# act_stream_unit

Streaming, parametrised activation stage placed between a convolution engine and the next pooling/conv layer. Accepts feature-map elements LANES at a time over a valid/ready handshake and applies a run-time selected activation: pass, ReLU, leaky ReLU or clipped ReLU. Tracks position within a NUM_CH × MAP_H × MAP_W frame, flags the last beat and pulses done when the frame has fully drained. Full throughput of one beat per cycle, 2-cycle latency.

## Interface
- BITWIDTH, 16, signed element width (two's complement)
- LANES, 4, elements per beat
- NUM_CH, 2, channels per frame
- MAP_H, 28, rows per channel
- MAP_W, 28, columns per channel; MAP_W % LANES must be 0
- LEAK_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAK_SHIFT
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches mode/cap, arms a frame (ignored unless IDLE)
- mode  in  2  0 pass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU
- cap  in  BITWIDTH-1  unsigned clip ceiling for mode 3
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  LANES*BITWIDTH  lane k at bits [k*BITWIDTH +: BITWIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*BITWIDTH  activated lanes, same packing
- out_last  out  1  high with final beat of frame
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last beat accepted downstream

## Operation
- FSM: IDLE -> (start) ACTIVE -> (last input beat accepted) DRAIN -> (last output beat accepted) IDLE, done=1 for that one cycle.
- start in ACTIVE/DRAIN ignored; mode/cap changes outside start have no effect mid-frame.
- Beat counters: col (step LANES, wraps at MAP_W), row (wraps at MAP_H), ch (wraps at NUM_CH). All zero on start. Input beat with col=MAP_W-LANES, row=MAP_H-1, ch=NUM_CH-1 is last; its tag travels with the data to out_last.
- in_ready = 0 in IDLE and DRAIN; extra input beyond the frame is never accepted.
- Per lane, x signed, sign = MSB:
  - mode 0: y = x
  - mode 1: y = sign ? 0 : x
  - mode 2: y = sign ? (x >>> LEAK_SHIFT) : x (arithmetic shift, rounds toward −∞; −1 -> −1)
  - mode 3: y = sign ? 0 : min(x, cap), unsigned compare of x[BITWIDTH-2:0] vs cap
- No width growth; outputs are exactly BITWIDTH, no overflow possible.
- Pipeline: S1 registers lane operands + last tag; S2 registers result. Each stage loads when empty or its content advances in the same cycle. in_ready = ACTIVE && (!s1_valid || s1 moves).

## Timing
- Reset: state IDLE, all counters 0, s1/s2 valid 0, in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0, latched mode 0, cap 0.
- Latency: beat accepted at edge N appears with out_valid at edge N+2 when out_ready held high.
- Throughput: 1 beat/cycle with out_ready=1; beats per frame = NUM_CH*MAP_H*MAP_W/LANES (392 at defaults).
- Backpressure: out_valid/out_data/out_last stable while out_valid && !out_ready; at most 2 beats buffered, then in_ready drops in the same cycle.
- Simultaneous accept in/out while both stages full: no bubble, no loss.
- busy rises the cycle after start; falls with done.
- rst mid-frame: all in-flight data discarded, outputs return to reset values immediately; done not pulsed.

## Configuration
- ACT_STATS_EN defined: adds output zero_count (out, 32) = number of lanes forced to 0 by modes 1/3 (negatives only; clip not counted) in the current frame; cleared on start, final value held from done until next start, 0 on reset.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- ReLU, defaults, lanes {−5, 0, 7, −32768} -> {0, 0, 7, 0} after 2 cycles; 392nd beat carries out_last, done one cycle after its acceptance.
- Leaky, LEAK_SHIFT=3, lanes {−8, −1, −17, 100} -> {−1, −1, −3, 100}.
- Clipped, cap=6, lanes {3, 6, 7, 32767} -> {3, 6, 6, 6}; negatives -> 0.
- Random out_ready (50%) over full frame vs reference model: no drop/duplicate, output held while stalled, in_ready never high in DRAIN, 393rd offered beat not accepted.
- rst asserted after 100 beats: out_valid/busy 0 immediately, no done; new start runs clean frame from col=row=ch=0.
- ACT_STATS_EN: frame of all −1 in ReLU -> zero_count = 1568 at done; mode 0 -> 0.
